// File: rtl/face_det_pkg.sv
`default_nettype none
// ============================================================================
// Module      : face_det_pkg
// Description : Shared definitions for the face bounding-box detector:
//               pixel-format selectors, the frame FSM state encoding, the
//               pixel-width helper and the RGB-to-gray conversion.
// Revision    : 1.0 - initial release
// ============================================================================
package face_det_pkg;

    localparam int c_pix_mode_rgb565 = 0;
    localparam int c_pix_mode_rgb888 = 1;

    typedef enum logic [1:0] {
        S_WAIT_SOF  = 2'd0,
        S_ACTIVE    = 2'd1,
        S_FINALIZE  = 2'd2
    } state_t;

    function automatic int pix_width(input int mode);
        return (mode == c_pix_mode_rgb888) ? 24 : 16;
    endfunction

    // RGB565 channels are widened by zero-filling the LSBs. Each weighted
    // term is at most 63/127/63, so the 8-bit sum tops out at 253.
    function automatic logic [7:0] rgb_to_gray(input logic [23:0] pix,
                                               input logic        is_888);
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        if (is_888) begin
            r = pix[23:16];
            g = pix[15:8];
            b = pix[7:0];
        end else begin
            r = {pix[15:11], 3'b000};
            g = {pix[10:5],  2'b00};
            b = {pix[4:0],   3'b000};
        end
        return (r >> 2) + (g >> 1) + (b >> 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pix_to_gray.sv
`default_nettype none
// ============================================================================
// Module      : pix_to_gray
// Description : Combinational pixel-to-gray converter for RGB565 or RGB888.
//               Ports: pix  - input pixel (16 or 24 bits, by PIX_MODE)
//                      gray - 8-bit luminance approximation
// Revision    : 1.0 - initial release
// ============================================================================
module pix_to_gray
    import face_det_pkg::*;
#(
    parameter  int PIX_MODE = 0,
    localparam int c_pix_w  = pix_width(PIX_MODE)
) (
    input  logic [c_pix_w-1:0] pix,
    output logic [7:0]         gray
);

    logic [23:0] w_pix24;

    generate
        if (c_pix_w == 24) begin : g_rgb888
            assign w_pix24 = pix;
        end else begin : g_rgb565
            assign w_pix24 = {8'd0, pix};
        end
    endgenerate

    assign gray = rgb_to_gray(w_pix24, (PIX_MODE == c_pix_mode_rgb888));

endmodule
`default_nettype wire

// File: rtl/face_bbox_detector.sv
`default_nettype none
// ============================================================================
// Module      : face_bbox_detector
// Description : Streaming bounding-box detector. Finds the extent of all
//               horizontal runs of in-band gray pixels in a frame, reports
//               the box once per frame and overlays the previous frame's box
//               onto the pixel stream with one cycle of latency.
//               Ports: clk, rst (sync, active high)
//                      pixel_in / data_valid_in / sof_in  - input stream
//                      pixel_out / data_valid_out         - overlaid stream
//                      face_detected, face_x/y/width/height, frame_done
// Revision    : 1.0 - initial release
// ============================================================================
module face_bbox_detector
    import face_det_pkg::*;
#(
    parameter  int          IMG_WIDTH   = 640,
    parameter  int          IMG_HEIGHT  = 480,
    parameter  int          PIX_MODE    = 0,
    parameter  int          MIN_SIZE    = 60,
    parameter  int          GRAY_LO     = 60,
    parameter  int          GRAY_HI     = 200,
    parameter  int          ROW_MIN_RUN = 8,
    parameter  logic [23:0] BOX_COLOR   = (PIX_MODE == 1) ? 24'hFF0000 : 24'h00F800,
    localparam int          c_pix_w     = pix_width(PIX_MODE),
    localparam int          c_cw        = $clog2(((IMG_WIDTH > IMG_HEIGHT) ? IMG_WIDTH : IMG_HEIGHT) + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [c_pix_w-1:0] pixel_in,
    input  logic               data_valid_in,
    input  logic               sof_in,
    output logic [c_pix_w-1:0] pixel_out,
    output logic               data_valid_out,
    output logic               face_detected,
    output logic               frame_done,
    output logic [c_cw-1:0]    face_x,
    output logic [c_cw-1:0]    face_y,
    output logic [c_cw-1:0]    face_width,
    output logic [c_cw-1:0]    face_height
);

    localparam int                 c_rw        = $clog2(ROW_MIN_RUN + 1);
    localparam logic [c_cw-1:0]    c_x_last    = c_cw'(IMG_WIDTH - 1);
    localparam logic [c_cw-1:0]    c_y_last    = c_cw'(IMG_HEIGHT - 1);
    localparam logic [c_cw-1:0]    c_run_back  = c_cw'(ROW_MIN_RUN - 1);
    localparam logic [c_cw-1:0]    c_min_size  = c_cw'(MIN_SIZE);
    localparam logic [c_rw-1:0]    c_run_max   = c_rw'(ROW_MIN_RUN);
    localparam logic [7:0]         c_gray_lo   = 8'(GRAY_LO);
    localparam logic [7:0]         c_gray_hi   = 8'(GRAY_HI);
    localparam logic [c_pix_w-1:0] c_box_color = BOX_COLOR[c_pix_w-1:0];

    state_t          r_state;
    logic [c_cw-1:0] r_x, r_y;
    logic [c_rw-1:0] r_run;
    logic            r_hit;
    logic [c_cw-1:0] r_min_x, r_max_x, r_min_y, r_max_y;
    logic            r_ov_valid;
    logic [c_cw-1:0] r_ov_x, r_ov_y, r_ov_w, r_ov_h;

    logic [7:0]      w_gray;
    logic            w_in_band, w_sof, w_count, w_fin;
    logic [c_cw-1:0] w_cx, w_cy, w_qx, w_x_next, w_y_next;
    logic            w_x_end, w_last;
    logic [c_rw-1:0] w_run_base, w_run_next;
    logic            w_qual, w_hit_base, w_hit_next;
    logic [c_cw-1:0] w_min_x_next, w_max_x_next, w_min_y_next, w_max_y_next;
    logic [c_cw-1:0] w_ext_w, w_ext_h;
    logic            w_det;
    logic            w_res_valid;
    logic [c_cw-1:0] w_res_x, w_res_y, w_res_w, w_res_h;
    logic            w_box_valid;
    logic [c_cw-1:0] w_box_x, w_box_y, w_box_w, w_box_h;
    logic [c_cw:0]   w_box_l, w_box_r, w_box_t, w_box_b, w_cx_e, w_cy_e;
    logic            w_on_col, w_on_row, w_in_rows, w_in_cols, w_on_border;

    pix_to_gray #(
        .PIX_MODE (PIX_MODE)
    ) u_pix_to_gray (
        .pix  (pixel_in),
        .gray (w_gray)
    );

    assign w_in_band = (w_gray >= c_gray_lo) && (w_gray <= c_gray_hi);

    // A pixel is counted when it opens a frame (from any state) or arrives
    // mid-frame; a start-of-frame pixel is always coordinate (0,0).
    assign w_sof   = data_valid_in & sof_in;
    assign w_count = data_valid_in & (sof_in | (r_state == S_ACTIVE));
    assign w_fin   = (r_state == S_FINALIZE);
    assign w_cx    = sof_in ? '0 : r_x;
    assign w_cy    = sof_in ? '0 : r_y;

    assign w_x_end  = (w_cx == c_x_last);
    assign w_last   = w_x_end && (w_cy == c_y_last);
    assign w_x_next = w_x_end ? '0 : w_cx + 1'b1;
    assign w_y_next = w_x_end ? w_cy + 1'b1 : w_cy;

    // Runs never span a line boundary; the counter saturates so a run of
    // any length keeps qualifying every pixel once it reaches the minimum.
    assign w_run_base = (w_cx == '0) ? '0 : r_run;
    assign w_run_next = !w_in_band                 ? '0 :
                        (w_run_base == c_run_max)  ? w_run_base :
                                                     w_run_base + 1'b1;
    assign w_qual     = w_in_band && (w_run_next == c_run_max);
    assign w_qx       = w_cx - c_run_back;   // left end of the qualifying run
    assign w_hit_base = sof_in ? 1'b0 : r_hit;

    always_comb begin
        w_hit_next   = w_hit_base;
        w_min_x_next = w_hit_base ? r_min_x : '0;
        w_max_x_next = w_hit_base ? r_max_x : '0;
        w_min_y_next = w_hit_base ? r_min_y : '0;
        w_max_y_next = w_hit_base ? r_max_y : '0;
        if (w_qual) begin
            w_hit_next   = 1'b1;
            w_max_y_next = w_cy;    // raster order: latest row is the lowest
            if (!w_hit_base) begin
                w_min_x_next = w_qx;
                w_max_x_next = w_cx;
                w_min_y_next = w_cy;
            end else begin
                if (w_qx < r_min_x) w_min_x_next = w_qx;
                if (w_cx > r_max_x) w_max_x_next = w_cx;
            end
        end
    end

    assign w_ext_w = r_max_x - r_min_x + 1'b1;
    assign w_ext_h = r_max_y - r_min_y + 1'b1;
    assign w_det   = r_hit && (w_ext_w >= c_min_size) && (w_ext_h >= c_min_size);

    // Result as it stands after this edge: a start-of-frame pixel arriving
    // in the finalize cycle must see the box being computed right now.
    assign w_res_valid = w_fin ? w_det : face_detected;
    assign w_res_x     = w_fin ? (w_det ? r_min_x : '0) : face_x;
    assign w_res_y     = w_fin ? (w_det ? r_min_y : '0) : face_y;
    assign w_res_w     = w_fin ? (w_det ? w_ext_w : '0) : face_width;
    assign w_res_h     = w_fin ? (w_det ? w_ext_h : '0) : face_height;

    assign w_box_valid = w_sof ? w_res_valid : r_ov_valid;
    assign w_box_x     = w_sof ? w_res_x     : r_ov_x;
    assign w_box_y     = w_sof ? w_res_y     : r_ov_y;
    assign w_box_w     = w_sof ? w_res_w     : r_ov_w;
    assign w_box_h     = w_sof ? w_res_h     : r_ov_h;

    assign w_box_l   = {1'b0, w_box_x};
    assign w_box_t   = {1'b0, w_box_y};
    assign w_box_r   = {1'b0, w_box_x} + {1'b0, w_box_w} - 1'b1;
    assign w_box_b   = {1'b0, w_box_y} + {1'b0, w_box_h} - 1'b1;
    assign w_cx_e    = {1'b0, w_cx};
    assign w_cy_e    = {1'b0, w_cy};
    assign w_on_col  = (w_cx_e == w_box_l) || (w_cx_e == w_box_r);
    assign w_on_row  = (w_cy_e == w_box_t) || (w_cy_e == w_box_b);
    assign w_in_rows = (w_cy_e >= w_box_t) && (w_cy_e <= w_box_b);
    assign w_in_cols = (w_cx_e >= w_box_l) && (w_cx_e <= w_box_r);
    assign w_on_border = w_count && w_box_valid &&
                         ((w_on_col && w_in_rows) || (w_on_row && w_in_cols));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_WAIT_SOF;
            r_x            <= '0;
            r_y            <= '0;
            r_run          <= '0;
            r_hit          <= 1'b0;
            r_min_x        <= '0;
            r_max_x        <= '0;
            r_min_y        <= '0;
            r_max_y        <= '0;
            r_ov_valid     <= 1'b0;
            r_ov_x         <= '0;
            r_ov_y         <= '0;
            r_ov_w         <= '0;
            r_ov_h         <= '0;
            pixel_out      <= '0;
            data_valid_out <= 1'b0;
            face_detected  <= 1'b0;
            frame_done     <= 1'b0;
            face_x         <= '0;
            face_y         <= '0;
            face_width     <= '0;
            face_height    <= '0;
        end else begin
            data_valid_out <= data_valid_in;
            frame_done     <= 1'b0;
            if (data_valid_in) begin
                pixel_out <= w_on_border ? c_box_color : pixel_in;
            end

            if (w_sof) begin
                r_ov_valid <= w_res_valid;
                r_ov_x     <= w_res_x;
                r_ov_y     <= w_res_y;
                r_ov_w     <= w_res_w;
                r_ov_h     <= w_res_h;
            end

            if (w_fin) begin
                face_detected <= w_det;
                face_x        <= w_res_x;
                face_y        <= w_res_y;
                face_width    <= w_res_w;
                face_height   <= w_res_h;
                frame_done    <= 1'b1;
                r_state       <= S_WAIT_SOF;
                r_x           <= '0;
                r_y           <= '0;
                r_run         <= '0;
                r_hit         <= 1'b0;
                r_min_x       <= '0;
                r_max_x       <= '0;
                r_min_y       <= '0;
                r_max_y       <= '0;
            end

            // Placed after the finalize branch so a new frame starting in the
            // finalize cycle overrides the cleared statistics.
            if (w_count) begin
                r_run   <= w_run_next;
                r_hit   <= w_hit_next;
                r_min_x <= w_min_x_next;
                r_max_x <= w_max_x_next;
                r_min_y <= w_min_y_next;
                r_max_y <= w_max_y_next;
                if (w_last) begin
                    r_state <= S_FINALIZE;
                    r_x     <= '0;
                    r_y     <= '0;
                end else begin
                    r_state <= S_ACTIVE;
                    r_x     <= w_x_next;
                    r_y     <= w_y_next;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_face_bbox_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_face_bbox_detector
// Description : Directed self-checking bench for face_bbox_detector on a
//               16x12 RGB565 image (MIN_SIZE 4, ROW_MIN_RUN 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_face_bbox_detector;

    localparam int          c_w     = 16;
    localparam logic [15:0] c_box   = 16'hF800;
    localparam int          c_npix  = 192;

    localparam int PAT_BLACK  = 0;
    localparam int PAT_BLOCK  = 1;
    localparam int PAT_SMALL  = 2;
    localparam int PAT_PAIRS  = 3;
    localparam int PAT_CORNER = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pixel_in;
    logic        data_valid_in;
    logic        sof_in;
    logic [15:0] pixel_out;
    logic        data_valid_out;
    logic        face_detected;
    logic        frame_done;
    logic [4:0]  face_x, face_y, face_width, face_height;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          fd_seen  = 0;
    logic [15:0] last_exp = 16'h0000;

    face_bbox_detector #(
        .IMG_WIDTH   (16),
        .IMG_HEIGHT  (12),
        .PIX_MODE    (0),
        .MIN_SIZE    (4),
        .GRAY_LO     (60),
        .GRAY_HI     (200),
        .ROW_MIN_RUN (3),
        .BOX_COLOR   (24'h00F800)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pixel_in       (pixel_in),
        .data_valid_in  (data_valid_in),
        .sof_in         (sof_in),
        .pixel_out      (pixel_out),
        .data_valid_out (data_valid_out),
        .face_detected  (face_detected),
        .frame_done     (frame_done),
        .face_x         (face_x),
        .face_y         (face_y),
        .face_width     (face_width),
        .face_height    (face_height)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // 0x8410 -> gray 128, 0x03C0 -> 60, 0xFFE6 -> 200 (in band);
    // 0x03A0 -> 58, 0xFFE7 -> 202 (just out of band).
    function automatic logic [15:0] pat_pix(input int pat, input int x, input int y);
        logic [15:0] p;
        p = 16'h0000;
        case (pat)
            PAT_BLOCK:
                if (x >= 5 && x <= 10 && y >= 3 && y <= 8)
                    p = (y == 3) ? 16'h03C0 : (y == 8) ? 16'hFFE6 : 16'h8410;
            PAT_SMALL:
                if (x >= 2 && x <= 4 && y >= 2 && y <= 4) p = 16'h8410;
            PAT_PAIRS:
                if (x == 0 || x == 1 || x == 6 || x == 7 || x == 14 || x == 15) p = 16'h8410;
                else if (x >= 3 && x <= 5)  p = 16'hFFE7;
                else if (x >= 9 && x <= 11) p = 16'h03A0;
            PAT_CORNER:
                if (x <= 3 && y <= 2) p = 16'h8410;
            default: p = 16'h0000;
        endcase
        return p;
    endfunction

    function automatic bit on_box(input int x, input int y);
        return ((x == 5 || x == 10) && y >= 3 && y <= 8) ||
               ((y == 3 || y == 8) && x >= 5 && x <= 10);
    endfunction

    task automatic send_pixels(input int pat, input int n, input bit sof_first, input bit ov_exp);
        int          x, y;
        logic [15:0] e;
        for (int i = 0; i < n; i++) begin
            x = i % c_w;
            y = i / c_w;
            pixel_in      = pat_pix(pat, x, y);
            data_valid_in = 1'b1;
            sof_in        = sof_first && (i == 0);
            e = (ov_exp && on_box(x, y)) ? c_box : pixel_in;
            tick();
            chk("pixel_out", pixel_out, e);
            chk("dv_out", data_valid_out, 1);
            if (frame_done === 1'b1) fd_seen++;
            last_exp = e;
        end
        data_valid_in = 1'b0;
        sof_in        = 1'b0;
    endtask

    task automatic chk_box(input bit det, input int x, input int y, input int w, input int h);
        chk("face_detected", face_detected, det);
        chk("face_x", face_x, x);
        chk("face_y", face_y, y);
        chk("face_width", face_width, w);
        chk("face_height", face_height, h);
    endtask

    task automatic finish_frame(input bit det, input int x, input int y, input int w, input int h);
        data_valid_in = 1'b0;
        sof_in        = 1'b0;
        tick();
        chk("frame_done_pulse", frame_done, 1);
        chk_box(det, x, y, w, h);
        chk("dv_out_idle", data_valid_out, 0);
        chk("pixel_out_hold", pixel_out, last_exp);
        tick();
        chk("frame_done_single", frame_done, 0);
    endtask

    initial begin
        rst           = 1'b1;
        data_valid_in = 1'b0;
        sof_in        = 1'b0;
        pixel_in      = 16'h0000;
        tick();
        tick();
        chk("rst_frame_done", frame_done, 0);
        chk("rst_dv_out", data_valid_out, 0);
        chk("rst_pixel_out", pixel_out, 0);
        chk_box(1'b0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();

        // Block with inclusive band edges on its top and bottom rows
        fd_seen = 0;
        send_pixels(PAT_BLOCK, c_npix, 1'b1, 1'b0);
        chk("no_done_in_frame", fd_seen, 0);
        finish_frame(1'b1, 5, 3, 6, 6);

        // Previous box drawn on a black frame
        send_pixels(PAT_BLACK, c_npix, 1'b1, 1'b1);
        finish_frame(1'b0, 0, 0, 0, 0);

        // Detection, then a 3x3 block that is too small
        send_pixels(PAT_BLOCK, c_npix, 1'b1, 1'b0);
        finish_frame(1'b1, 5, 3, 6, 6);
        send_pixels(PAT_SMALL, c_npix, 1'b1, 1'b1);
        finish_frame(1'b0, 0, 0, 0, 0);

        // Runs of two only, followed back-to-back by a frame whose sof lands
        // in the finalize cycle: overlay must reflect the no-detect result
        send_pixels(PAT_BLOCK, c_npix, 1'b1, 1'b0);
        finish_frame(1'b1, 5, 3, 6, 6);
        fd_seen = 0;
        send_pixels(PAT_PAIRS, c_npix, 1'b1, 1'b1);
        send_pixels(PAT_BLACK, c_npix, 1'b1, 1'b0);
        chk("b2b_done_count", fd_seen, 1);
        chk_box(1'b0, 0, 0, 0, 0);
        finish_frame(1'b0, 0, 0, 0, 0);

        // Back-to-back detection: overlay must use the just-computed box
        fd_seen = 0;
        send_pixels(PAT_BLOCK, c_npix, 1'b1, 1'b0);
        send_pixels(PAT_BLACK, c_npix, 1'b1, 1'b1);
        chk("bypass_done_count", fd_seen, 1);
        chk_box(1'b1, 5, 3, 6, 6);
        finish_frame(1'b0, 0, 0, 0, 0);

        // Frame aborted by sof at pixel 50
        fd_seen = 0;
        send_pixels(PAT_CORNER, 50, 1'b1, 1'b0);
        send_pixels(PAT_BLOCK, c_npix, 1'b1, 1'b0);
        chk("abort_done_count", fd_seen, 0);
        finish_frame(1'b1, 5, 3, 6, 6);

        // Reset at pixel 100
        send_pixels(PAT_BLOCK, 100, 1'b1, 1'b1);
        rst           = 1'b1;
        pixel_in      = 16'h8410;
        data_valid_in = 1'b1;
        tick();
        chk("rstmid_dv_out", data_valid_out, 0);
        chk("rstmid_pixel_out", pixel_out, 0);
        chk("rstmid_frame_done", frame_done, 0);
        chk_box(1'b0, 0, 0, 0, 0);
        rst           = 1'b0;
        data_valid_in = 1'b0;
        fd_seen       = 0;
        send_pixels(PAT_BLOCK, c_npix, 1'b0, 1'b0);
        tick();
        if (frame_done === 1'b1) fd_seen++;
        tick();
        if (frame_done === 1'b1) fd_seen++;
        chk("rstmid_no_done", fd_seen, 0);
        chk_box(1'b0, 0, 0, 0, 0);

        // Recovery with a fresh frame
        send_pixels(PAT_BLOCK, c_npix, 1'b1, 1'b0);
        chk("recover_no_early_done", fd_seen, 0);
        finish_frame(1'b1, 5, 3, 6, 6);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
